// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the single-cycle RV32 core.
// Serves instruction fetches, data loads/stores and a small peripheral window
// (cycle counter, GPIO, compare timer). All read paths are combinational
// because the core has no wait states; all state changes happen at posedge clk.
module cpu_mem_responder #(
  parameter int unsigned IMEM_WORDS  = 256,
  parameter int unsigned DMEM_WORDS  = 256,
  parameter logic [31:0] PERIPH_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        data_write,
  output logic [31:0] data_in,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic        irq
);

  localparam int          IAW        = $clog2(IMEM_WORDS);
  localparam int          DAW        = $clog2(DMEM_WORDS);
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS) << 2;
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS) << 2;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  // Peripheral register word offsets (byte offset / 4)
  localparam logic [2:0] OFF_CYCLE    = 3'd0;
  localparam logic [2:0] OFF_GPIO_OUT = 3'd1;
  localparam logic [2:0] OFF_GPIO_IN  = 3'd2;
  localparam logic [2:0] OFF_CMP      = 3'd3;
  localparam logic [2:0] OFF_STAT     = 3'd4;

  // ---------------------------------------------------------------------------
  // Instruction RAM
  // ---------------------------------------------------------------------------
  logic [31:0]    imem [IMEM_WORDS];
  logic [IAW-1:0] inst_idx;
  logic [IAW-1:0] prog_idx;
  logic           inst_in_range;
  logic           prog_in_range;

  assign inst_idx      = inst_addr[2 +: IAW];
  assign prog_idx      = prog_addr[2 +: IAW];
  assign inst_in_range = (inst_addr < IMEM_BYTES);
  assign prog_in_range = (prog_addr < IMEM_BYTES);

  // Loader writes; out-of-range addresses are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (prog_we && prog_in_range) begin
      imem[prog_idx] <= prog_data;
    end
  end

  // Fetches beyond the RAM return a NOP so a runaway PC cannot execute garbage.
  assign inst_data = inst_in_range ? imem[inst_idx] : NOP_INSN;

  // ---------------------------------------------------------------------------
  // Data address decode and data RAM
  // ---------------------------------------------------------------------------
  logic [31:0]    dmem [DMEM_WORDS];
  logic [DAW-1:0] dmem_idx;
  logic           dmem_hit;
  logic           periph_hit;
  logic [2:0]     periph_off;
  logic           dmem_we;
  logic           periph_we;

  assign dmem_idx   = data_addr[2 +: DAW];
  assign dmem_hit   = (data_addr < DMEM_BYTES);
  assign periph_hit = (data_addr[31:5] == PERIPH_BASE[31:5]);
  assign periph_off = data_addr[4:2];
  // A store that coincides with reset being asserted is dropped.
  assign dmem_we    = data_write && dmem_hit && rst_n;
  assign periph_we  = data_write && periph_hit && !dmem_hit;

  // Data RAM write port; the combinational read below sees the old word
  // during the write cycle.
  always_ff @(posedge clk) begin
    if (dmem_we) begin
      dmem[dmem_idx] <= data_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Peripheral registers
  // ---------------------------------------------------------------------------
  logic [31:0] cycle_reg;
  logic [31:0] cycle_next;
  logic [31:0] cmp_reg;
  logic [31:0] cmp_next;
  logic [7:0]  gpio_out_reg;
  logic [7:0]  gpio_out_next;
  logic        match_reg;
  logic        match_next;
  logic        ie_reg;
  logic        ie_next;
  logic        match_hit;
  logic        match_clr;
  logic [7:0]  gpio_sync;

  // Two-flop synchronizer per GPIO input pin.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_gpio_sync
      logic meta_reg;
      logic sync_reg;

      // Each pin settles through two flops before software can observe it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= gpio_in[gi];
          sync_reg <= meta_reg;
        end
      end

      assign gpio_sync[gi] = sync_reg;
    end
  endgenerate

  // Next-state for counter, compare timer and GPIO output; MATCH set beats
  // a simultaneous write-1-to-clear.
  always_comb begin
    cycle_next    = cycle_reg + 32'd1;
    cmp_next      = cmp_reg;
    gpio_out_next = gpio_out_reg;
    ie_next       = ie_reg;
    match_clr     = 1'b0;
    match_hit     = (cycle_reg == cmp_reg);
    if (periph_we) begin
      case (periph_off)
        OFF_GPIO_OUT: gpio_out_next = data_out[7:0];
        OFF_CMP:      cmp_next      = data_out;
        OFF_STAT: begin
          ie_next   = data_out[1];
          match_clr = data_out[0];
        end
        default: ;
      endcase
    end
    match_next = match_hit | (match_reg & ~match_clr);
  end

  // Peripheral state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_reg    <= 32'h0;
      cmp_reg      <= 32'hFFFF_FFFF;
      gpio_out_reg <= 8'h0;
      match_reg    <= 1'b0;
      ie_reg       <= 1'b0;
    end else begin
      cycle_reg    <= cycle_next;
      cmp_reg      <= cmp_next;
      gpio_out_reg <= gpio_out_next;
      match_reg    <= match_next;
      ie_reg       <= ie_next;
    end
  end

  assign gpio_out = gpio_out_reg;
  assign irq      = match_reg & ie_reg;

  // ---------------------------------------------------------------------------
  // Load data mux
  // ---------------------------------------------------------------------------
  logic [31:0] periph_rdata;

  // Peripheral read mux; unused offsets read as zero.
  always_comb begin
    periph_rdata = 32'h0;
    case (periph_off)
      OFF_CYCLE:    periph_rdata = cycle_reg;
      OFF_GPIO_OUT: periph_rdata = {24'h0, gpio_out_reg};
      OFF_GPIO_IN:  periph_rdata = {24'h0, gpio_sync};
      OFF_CMP:      periph_rdata = cmp_reg;
      OFF_STAT:     periph_rdata = {30'h0, ie_reg, match_reg};
      default:      periph_rdata = 32'h0;
    endcase
  end

  // Select the load source; unmapped addresses read as zero.
  always_comb begin
    data_in = 32'h0;
    if (dmem_hit) begin
      data_in = dmem[dmem_idx];
    end else if (periph_hit) begin
      data_in = periph_rdata;
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios plus random
// traffic, checked against a behavioural memory/peripheral model.
`timescale 1ns/1ps
module tb_cpu_mem_responder;

  localparam int          IMEM_WORDS = 256;
  localparam int          DMEM_WORDS = 256;
  localparam int          IIX        = 8;
  localparam int          DIX        = 8;
  localparam logic [31:0] PB         = 32'h8000_0000;
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic [31:0] data_addr;
  logic [31:0] data_out;
  logic        data_write;
  logic [31:0] data_in;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        irq;

  always #5 clk = ~clk;

  cpu_mem_responder #(
    .IMEM_WORDS (IMEM_WORDS),
    .DMEM_WORDS (DMEM_WORDS),
    .PERIPH_BASE(PB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst_addr (inst_addr),
    .inst_data (inst_data),
    .data_addr (data_addr),
    .data_out  (data_out),
    .data_write(data_write),
    .data_in   (data_in),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .irq       (irq)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] imem_m [IMEM_WORDS];
  logic [31:0] dmem_m [DMEM_WORDS];
  logic [31:0] cyc_m;
  logic [31:0] cmp_m;
  logic [7:0]  gout_m;
  logic        match_m;
  logic        ie_m;
  logic [7:0]  gq [$];   // gq[0] is what software sees on GPIO_IN

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_if(input logic [31:0] a);
    if (a >= IMEM_BYTES) return 32'h0000_0013;
    return imem_m[a[2 +: IIX]];
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a < DMEM_BYTES) return dmem_m[a[2 +: DIX]];
    if ((a >> 5) != (PB >> 5)) return 32'h0;
    case (a[4:2])
      3'd0:    return cyc_m;
      3'd1:    return {24'h0, gout_m};
      3'd2:    return {24'h0, gq[0]};
      3'd3:    return cmp_m;
      3'd4:    return {30'h0, ie_m, match_m};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    cyc_m   = 32'h0;
    cmp_m   = 32'hFFFF_FFFF;
    gout_m  = 8'h0;
    match_m = 1'b0;
    ie_m    = 1'b0;
    gq.delete();
    gq.push_back(8'h0);
    gq.push_back(8'h0);
  endtask

  // Apply the effect of one rising clock edge to the model.
  task automatic model_edge();
    logic hit;
    logic clr;
    if (prog_we && prog_addr < IMEM_BYTES) imem_m[prog_addr[2 +: IIX]] = prog_data;
    if (rst_n) begin
      hit = (cyc_m == cmp_m);
      clr = 1'b0;
      if (data_write) begin
        if (data_addr < DMEM_BYTES) begin
          dmem_m[data_addr[2 +: DIX]] = data_out;
        end else if ((data_addr >> 5) == (PB >> 5)) begin
          case (data_addr[4:2])
            3'd1: gout_m = data_out[7:0];
            3'd3: cmp_m = data_out;
            3'd4: begin
              ie_m = data_out[1];
              clr  = data_out[0];
            end
            default: ;
          endcase
        end
      end
      match_m = hit || (match_m && !clr);
      cyc_m   = cyc_m + 32'd1;
      gq.push_back(gpio_in);
      void'(gq.pop_front());
    end
  endtask

  // One bus cycle: drive, check combinational outputs mid-cycle, clock, update model.
  task automatic step(input string tag, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input bit rd_chk);
    data_write = we;
    data_addr  = a;
    data_out   = d;
    @(negedge clk);
    if (rd_chk) chk({tag, "/rd"}, data_in, exp_rd(a));
    chk({tag, "/if"}, inst_data, exp_if(inst_addr));
    chk({tag, "/irq"}, {31'h0, irq}, {31'h0, match_m & ie_m});
    chk({tag, "/gpo"}, {24'h0, gpio_out}, {24'h0, gout_m});
    @(posedge clk);
    model_edge();
    #1;
    data_write = 1'b0;
    prog_we    = 1'b0;
  endtask

  task automatic rd_now(input string tag, input logic [31:0] a, input logic [31:0] exp);
    data_write = 1'b0;
    data_addr  = a;
    #1;
    chk(tag, data_in, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    logic [31:0] saved_cmp;
    logic [31:0] old;
    int          k;

    inst_addr  = IMEM_BYTES;
    data_addr  = PB;
    data_out   = 32'h0;
    data_write = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = 32'h0;
    prog_data  = 32'h0;
    gpio_in    = 8'h0;
    model_reset();

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gpo", {24'h0, gpio_out}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rd_now("rst_cyc", PB, 32'h0);
    rd_now("rst_cmp", PB + 32'hC, 32'hFFFF_FFFF);
    rd_now("rst_stat", PB + 32'h10, 32'h0);

    // Program the instruction RAM while in reset
    for (int i = 0; i < IMEM_WORDS; i++) begin
      prog_we   = 1'b1;
      prog_addr = 32'(i * 4);
      prog_data = (i == 0) ? 32'h0020_81B3 : (i == 1) ? 32'h4020_8233 : $urandom;
      step("ipre", 1'b0, PB, 32'h0, 1'b1);
    end
    // Out-of-range loader write must not alias onto word 1
    prog_we = 1'b1; prog_addr = IMEM_BYTES + 32'h4; prog_data = 32'hBAD0_BAD0;
    step("iprog_oor", 1'b0, PB, 32'h0, 1'b1);

    rst_n = 1'b1;
    inst_addr = 32'h4;
    #1 chk("fetch_4", inst_data, 32'h4020_8233);
    inst_addr = IMEM_BYTES;
    #1 chk("fetch_nop", inst_data, 32'h0000_0013);

    // Fetch of a word being programmed returns the old contents
    inst_addr = 32'h14;
    prog_we = 1'b1; prog_addr = 32'h14; prog_data = 32'h1234_5678;
    step("iprog_rdw", 1'b0, PB, 32'h0, 1'b1);
    step("iprog_new", 1'b0, PB, 32'h0, 1'b1);

    // Fill data RAM
    for (int i = 0; i < DMEM_WORDS; i++) begin
      inst_addr = 32'($urandom_range(0, IMEM_WORDS - 1)) << 2;
      step("dpre", 1'b1, 32'(i * 4), $urandom, 1'b0);
    end

    // Store then load, read-during-write sees the old word
    step("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1);
    rd_now("ld10", 32'h10, 32'hDEAD_BEEF);
    rd_now("ld14", 32'h14, dmem_m[5]);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int          sel;
      logic [31:0] a;
      sel       = $urandom_range(0, 9);
      gpio_in   = 8'($urandom);
      inst_addr = 32'($urandom_range(0, 2 * IMEM_WORDS - 1)) << 2;
      case (sel)
        0, 1, 2, 3: a = 32'($urandom_range(0, DMEM_WORDS - 1)) << 2;
        4, 5:       a = PB + (32'($urandom_range(0, 7)) << 2);
        6:          a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
        7:          a = $urandom;
        default: begin
          a         = 32'($urandom_range(0, DMEM_WORDS - 1)) << 2;
          prog_we   = 1'b1;
          prog_addr = 32'($urandom_range(0, 2 * IMEM_WORDS - 1)) << 2;
          prog_data = $urandom;
        end
      endcase
      step("rnd", 1'($urandom_range(0, 1)), a, $urandom, 1'b1);
    end

    // GPIO output and synchronized input latency
    step("gpo_w", 1'b1, PB + 32'h4, 32'h0000_01A5, 1'b1);
    chk("gpo_pin", {24'h0, gpio_out}, 32'hA5);
    rd_now("gpo_rd", PB + 32'h4, 32'hA5);
    gpio_in = 8'h0;
    step("gin_z0", 1'b0, PB + 32'h8, 32'h0, 1'b1);
    step("gin_z1", 1'b0, PB + 32'h8, 32'h0, 1'b1);
    gpio_in = 8'h3C;
    step("gin0", 1'b0, PB + 32'h8, 32'h0, 1'b1);
    rd_now("gin_1cyc", PB + 32'h8, 32'h0);
    step("gin1", 1'b0, PB + 32'h8, 32'h0, 1'b1);
    rd_now("gin_2cyc", PB + 32'h8, 32'h3C);

    // Timer: quiesce, then arm CMP = CYCLE + 5
    step("tm_cmpmax", 1'b1, PB + 32'hC, 32'hFFFF_FFFF, 1'b1);
    step("tm_quiet", 1'b1, PB + 32'h10, 32'h1, 1'b1);
    c = cyc_m;
    step("tm_rdcyc", 1'b0, PB, 32'h0, 1'b1);
    step("tm_cmp", 1'b1, PB + 32'hC, c + 32'd5, 1'b1);
    step("tm_ie", 1'b1, PB + 32'h10, 32'h2, 1'b1);
    k = 2;
    while (k < 25 && irq !== 1'b1) begin
      step("tm_wait", 1'b0, PB + 32'h10, 32'h0, 1'b1);
      k++;
    end
    chk("tm_latency", 32'(k), 32'd5);
    rd_now("tm_stat_set", PB + 32'h10, 32'h3);

    // Clear MATCH, IE stays set
    step("tm_clr", 1'b1, PB + 32'h10, 32'h3, 1'b1);
    chk("tm_irq_clr", {31'h0, irq}, 32'h0);
    rd_now("tm_stat_clr", PB + 32'h10, 32'h2);

    // CMP written equal to the current CYCLE never fires
    step("tm_cmp_now", 1'b1, PB + 32'hC, cyc_m, 1'b1);
    for (int i = 0; i < 3; i++) step("tm_nofire", 1'b0, PB + 32'h10, 32'h0, 1'b1);
    rd_now("tm_nofire_stat", PB + 32'h10, 32'h2);

    // Clear issued in the match cycle: set wins
    saved_cmp = cyc_m + 32'd3;
    step("tm_cmp3", 1'b1, PB + 32'hC, saved_cmp, 1'b1);
    step("tm_w1", 1'b0, PB + 32'h10, 32'h0, 1'b1);
    step("tm_w2", 1'b0, PB + 32'h10, 32'h0, 1'b1);
    step("tm_clr_race", 1'b1, PB + 32'h10, 32'h3, 1'b1);
    rd_now("tm_set_wins", PB + 32'h10, 32'h3);
    chk("tm_set_wins_irq", {31'h0, irq}, 32'h1);

    // Unmapped and reserved accesses
    step("um_w1", 1'b1, 32'h4000_0000, 32'h5555_AAAA, 1'b1);
    step("um_w2", 1'b1, PB + 32'h18, 32'hFFFF_FFFF, 1'b1);
    rd_now("um_r1", 32'h4000_0000, 32'h0);
    rd_now("um_r2", PB + 32'h18, 32'h0);
    step("um_gap", 1'b0, PB, 32'h0, 1'b1);
    rd_now("um_gpo", PB + 32'h4, 32'hA5);
    rd_now("um_cmp", PB + 32'hC, saved_cmp);
    step("um_gap2", 1'b0, PB, 32'h0, 1'b1);
    rd_now("um_d0", 32'h0, dmem_m[0]);
    rd_now("um_stat", PB + 32'h10, 32'h3);

    // Reset mid-store with the timer firing
    step("rs_clr", 1'b1, PB + 32'h10, 32'h3, 1'b1);
    step("rs_arm", 1'b1, PB + 32'hC, cyc_m + 32'd2, 1'b1);
    for (int i = 0; i < 3; i++) step("rs_wait", 1'b0, PB, 32'h0, 1'b1);
    chk("rs_irq_pre", {31'h0, irq}, 32'h1);
    old        = dmem_m[8];
    data_write = 1'b1;
    data_addr  = 32'h20;
    data_out   = ~old;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rs_gpo", {24'h0, gpio_out}, 32'h0);
    chk("rs_irq", {31'h0, irq}, 32'h0);
    chk("rs_dold", data_in, old);
    model_reset();
    @(posedge clk);
    model_edge();
    #1;
    data_write = 1'b0;
    rd_now("rs_cyc", PB, 32'h0);
    rd_now("rs_stat", PB + 32'h10, 32'h0);
    rst_n = 1'b1;
    rd_now("rs_dmem", 32'h20, old);
    step("rs_c0", 1'b0, PB, 32'h0, 1'b1);
    step("rs_c1", 1'b0, PB, 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
